// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializer_pkg
// Purpose  : Shared types and default sizing for the serializer/deserializer
//            pair. The frame FSM state encoding lives here so that both ends
//            of the link agree on it.
// Revision : 1.0 - initial release
// ============================================================================
package serializer_pkg;

   // Default element width in bits and elements per parallel vector.
   localparam int DEFAULT_ELEMENT_BITS = 8;
   localparam int DEFAULT_FEATURES     = 4;

   // Frame FSM: idle/ready, sending vector 1, sending vector 2.
   typedef enum logic [1:0] {
      RDY = 2'd0,
      R1  = 2'd1,
      R2  = 2'd2
   } ser_state_t;

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Purpose  : Captures two parallel vectors on start and streams their
//            elements out one at a time (vector 1 then vector 2, element 0
//            first) over a valid/ready interface. A one-cycle done pulse
//            marks frame completion; start in the done cycle begins the next
//            frame immediately.
// Revision : 1.0 - initial release
// ============================================================================
module serializer
   import serializer_pkg::*;
#(
   parameter int ELEMENT_BITS = DEFAULT_ELEMENT_BITS,
   parameter int FEATURES     = DEFAULT_FEATURES
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             start,
   input  logic [ELEMENT_BITS*FEATURES-1:0] parallel_data_in_1,
   input  logic [ELEMENT_BITS*FEATURES-1:0] parallel_data_in_2,
   input  logic                             serial_ready,
   output logic [ELEMENT_BITS-1:0]          serial_data_out,
   output logic                             serial_valid,
   output logic                             serial_last,
   output logic                             busy,
   output logic                             done
);

   localparam int               c_IW       = (FEATURES > 1) ? $clog2(FEATURES) : 1;
   localparam int               c_VW       = ELEMENT_BITS * FEATURES;
   localparam logic [c_IW-1:0]  c_LAST_IDX = c_IW'(FEATURES - 1);

   // A frame needs at least two elements per vector; catch bad parameters
   // at elaboration instead of producing a silently broken index counter.
   if (FEATURES < 2) begin : g_bad_features
      $error("serializer: FEATURES must be 2 or more");
   end

   ser_state_t              r_state;
   logic [c_IW-1:0]         r_idx;
   logic [c_VW-1:0]         r_vec1;
   logic [c_VW-1:0]         r_vec2;
   logic [ELEMENT_BITS-1:0] r_data;
   logic                    r_valid;
   logic                    r_last;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_xfer;
   logic                    w_at_last;
   logic [c_IW-1:0]         w_idx_next;
   logic [ELEMENT_BITS-1:0] w_v1_next_elem;
   logic [ELEMENT_BITS-1:0] w_v2_next_elem;

   // Handshake and next-element lookup. The lookahead element is only used
   // when the index is not at its last position, so the wrapped value of
   // w_idx_next at the end of a vector is never consumed.
   assign w_xfer         = r_valid & serial_ready;
   assign w_at_last      = (r_idx == c_LAST_IDX);
   assign w_idx_next     = r_idx + 1'b1;
   assign w_v1_next_elem = r_vec1[w_idx_next*ELEMENT_BITS +: ELEMENT_BITS];
   assign w_v2_next_elem = r_vec2[w_idx_next*ELEMENT_BITS +: ELEMENT_BITS];

   // Frame FSM with index counter, shadow vectors and registered outputs.
   // Outputs are loaded with the value belonging to the next state so that
   // they always agree with r_state/r_idx in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RDY;
         r_idx   <= '0;
         r_vec1  <= '0;
         r_vec2  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            RDY: begin
               r_done <= 1'b0;
               if (start) begin
                  // Capture both vectors; the first element comes straight
                  // from the input so it is presented one cycle after start.
                  r_vec1  <= parallel_data_in_1;
                  r_vec2  <= parallel_data_in_2;
                  r_state <= R1;
                  r_idx   <= '0;
                  r_data  <= parallel_data_in_1[ELEMENT_BITS-1:0];
                  r_valid <= 1'b1;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_idx   <= '0;
                  r_data  <= '0;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end

            R1: begin
               r_done <= 1'b0;
               if (w_xfer) begin
                  if (w_at_last) begin
                     // Vector 1 exhausted: continue with vector 2, element 0.
                     r_state <= R2;
                     r_idx   <= '0;
                     r_data  <= r_vec2[ELEMENT_BITS-1:0];
                     r_last  <= 1'b0;
                  end else begin
                     r_idx   <= w_idx_next;
                     r_data  <= w_v1_next_elem;
                  end
               end
            end

            R2: begin
               r_done <= 1'b0;
               if (w_xfer) begin
                  if (w_at_last) begin
                     // Final element accepted: frame complete.
                     r_state <= RDY;
                     r_idx   <= '0;
                     r_data  <= '0;
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= w_idx_next;
                     r_data  <= w_v2_next_elem;
                     r_last  <= (w_idx_next == c_LAST_IDX);
                  end
               end
            end

            default: begin
               r_state <= RDY;
               r_idx   <= '0;
               r_data  <= '0;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign serial_data_out = r_data;
   assign serial_valid    = r_valid;
   assign serial_last     = r_last;
   assign busy            = r_busy;
   assign done            = r_done;

endmodule : serializer
`default_nettype wire
